fa_serial_sequencer: RTL and testbench

//  Bit-serial controller that time-shares one external full-adder cell (A, B, C_in -> Sum, C_out)

---
 rtl/fa_serial_sequencer.sv | 149 ++++++++++++++
 tb/tb_fa_serial_sequencer.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/fa_serial_sequencer.sv
// Bit-serial adder controller sharing one external full-adder cell between two requesters; FA_SEQ_SUB_EN adds A-B via req*_sub.
// Result valid WIDTH+1 cycles after accept, held until res_ready; no new accept until the result is taken.
module fa_serial_sequencer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req0_cin,
`ifdef FA_SEQ_SUB_EN
  input  logic             req0_sub,
`endif
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic             req1_cin,
`ifdef FA_SEQ_SUB_EN
  input  logic             req1_sub,
`endif
  output logic             req1_ready,
  output logic             fa_a,
  output logic             fa_b,
  output logic             fa_cin,
  input  logic             fa_sum,
  input  logic             fa_cout,
  output logic             res_valid,
  output logic [WIDTH-1:0] res_sum,
  output logic             res_cout,
  output logic             res_id,
  input  logic             res_ready
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic             rr_q, rr_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] sum_sh_q, sum_sh_d;
  logic             carry_q, carry_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             res_id_q, res_id_d;

  logic             grant;
  logic             any_vld;
  logic             sel_sub;
  logic [WIDTH-1:0] sel_a;
  logic [WIDTH-1:0] sel_b;
  logic             sel_cin;

  // Pointer only matters on contention; a lone requester is always granted.
  assign any_vld = req0_valid | req1_valid;
  assign grant   = (req0_valid & req1_valid) ? rr_q : req1_valid;
  assign sel_a   = grant ? req1_a   : req0_a;
  assign sel_b   = grant ? req1_b   : req0_b;
  assign sel_cin = grant ? req1_cin : req0_cin;
`ifdef FA_SEQ_SUB_EN
  assign sel_sub = grant ? req1_sub : req0_sub;
`else
  assign sel_sub = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    rr_d       = rr_q;
    a_sh_d     = a_sh_q;
    b_sh_d     = b_sh_q;
    sum_sh_d   = sum_sh_q;
    carry_d    = carry_q;
    cnt_d      = cnt_q;
    res_id_d   = res_id_q;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    fa_a       = 1'b0;
    fa_b       = 1'b0;
    fa_cin     = 1'b0;
    res_valid  = 1'b0;
    res_sum    = '0;
    res_cout   = 1'b0;
    res_id     = 1'b0;

    unique case (state_q)
      IDLE: begin
        req0_ready = rst_n & any_vld & ~grant;
        req1_ready = rst_n & any_vld & grant;
        if (any_vld) begin
          a_sh_d   = sel_a;
          b_sh_d   = sel_sub ? ~sel_b : sel_b;
          carry_d  = sel_sub | sel_cin;
          cnt_d    = '0;
          res_id_d = grant;
          rr_d     = ~grant;
          state_d  = RUN;
        end
      end
      RUN: begin
        fa_a     = a_sh_q[0];
        fa_b     = b_sh_q[0];
        fa_cin   = carry_q;
        sum_sh_d = {fa_sum, sum_sh_q[WIDTH-1:1]};
        carry_d  = fa_cout;
        a_sh_d   = a_sh_q >> 1;
        b_sh_d   = b_sh_q >> 1;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        res_valid = 1'b1;
        res_sum   = sum_sh_q;
        res_cout  = carry_q;
        res_id    = res_id_q;
        if (res_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      rr_q     <= 1'b0;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      sum_sh_q <= '0;
      carry_q  <= 1'b0;
      cnt_q    <= '0;
      res_id_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      rr_q     <= rr_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      sum_sh_q <= sum_sh_d;
      carry_q  <= carry_d;
      cnt_q    <= cnt_d;
      res_id_q <= res_id_d;
    end
  end

endmodule

// File: tb/tb_fa_serial_sequencer.sv
// Directed bench for fa_serial_sequencer with a behavioural full-adder cell and an expected-result queue.
module tb_fa_serial_sequencer;

  localparam int W = 8;

  typedef struct packed {
    logic [W-1:0] sum;
    logic         cout;
    logic         id;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         req0_valid, req0_cin, req0_ready;
  logic [W-1:0] req0_a, req0_b;
  logic         req1_valid, req1_cin, req1_ready;
  logic [W-1:0] req1_a, req1_b;
  logic         fa_a, fa_b, fa_cin, fa_sum, fa_cout;
  logic         res_valid, res_cout, res_id, res_ready;
  logic [W-1:0] res_sum;
`ifdef FA_SEQ_SUB_EN
  logic         req0_sub, req1_sub;
`endif

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  int   acc_cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign fa_sum  = fa_a ^ fa_b ^ fa_cin;
  assign fa_cout = (fa_a & fa_b) | (fa_a & fa_cin) | (fa_b & fa_cin);

  fa_serial_sequencer #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b), .req0_cin(req0_cin),
`ifdef FA_SEQ_SUB_EN
    .req0_sub(req0_sub),
`endif
    .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b), .req1_cin(req1_cin),
`ifdef FA_SEQ_SUB_EN
    .req1_sub(req1_sub),
`endif
    .req1_ready(req1_ready),
    .fa_a(fa_a), .fa_b(fa_b), .fa_cin(fa_cin), .fa_sum(fa_sum), .fa_cout(fa_cout),
    .res_valid(res_valid), .res_sum(res_sum), .res_cout(res_cout), .res_id(res_id),
    .res_ready(res_ready)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic exp_t model(input logic id, input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic cin, input logic sub);
    logic [W:0] s;
    exp_t e;
    s      = {1'b0, a} + {1'b0, (sub ? ~b : b)} + {{W{1'b0}}, (sub | cin)};
    e.sum  = s[W-1:0];
    e.cout = s[W];
    e.id   = id;
    return e;
  endfunction

  // Called just after a falling edge; returns just after the falling edge following the accept.
  task automatic issue(input logic id, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic cin, input logic sub);
    int   k;
    logic rdy;
    if (id == 1'b0) begin
      req0_valid = 1'b1; req0_a = a; req0_b = b; req0_cin = cin;
`ifdef FA_SEQ_SUB_EN
      req0_sub = sub;
`endif
    end else begin
      req1_valid = 1'b1; req1_a = a; req1_b = b; req1_cin = cin;
`ifdef FA_SEQ_SUB_EN
      req1_sub = sub;
`endif
    end
    k = 0;
    forever begin
      #1;
      rdy = id ? req1_ready : req0_ready;
      if (rdy || k >= 40) break;
      @(negedge clk);
      k++;
    end
    chk($sformatf("accept_ready_req%0d", id), {31'b0, rdy}, 32'd1);
    chk("ready_onehot", {31'b0, req0_ready & req1_ready}, 32'd0);
    acc_cyc = cyc;
    exp_q.push_back(model(id, a, b, cin, sub));
    @(negedge clk);
    if (id == 1'b0) req0_valid = 1'b0;
    else            req1_valid = 1'b0;
  endtask

  // Waits for a result, checks it against the queue head, optionally stalls, then handshakes.
  task automatic get_result(input int hold, input bit check_lat);
    int   k;
    exp_t e;
    k = 0;
    forever begin
      #1;
      if (res_valid || k >= 40) break;
      @(negedge clk);
      k++;
    end
    chk("res_valid_seen", {31'b0, res_valid}, 32'd1);
    if (check_lat) chk("latency", cyc - acc_cyc, W + 1);
    if (exp_q.size() == 0) begin
      chk("scoreboard_nonempty", 32'd0, 32'd1);
      e = '0;
    end else begin
      e = exp_q.pop_front();
    end
    chk("res_sum", {24'b0, res_sum}, {24'b0, e.sum});
    chk("res_cout", {31'b0, res_cout}, {31'b0, e.cout});
    chk("res_id", {31'b0, res_id}, {31'b0, e.id});
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      #1;
      chk("hold_valid", {31'b0, res_valid}, 32'd1);
      chk("hold_sum", {24'b0, res_sum}, {24'b0, e.sum});
      chk("hold_cout_id", {30'b0, res_cout, res_id}, {30'b0, e.cout, e.id});
      chk("hold_no_accept", {30'b0, req0_ready, req1_ready}, 32'd0);
    end
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
  endtask

  initial begin
    int seen;
    rst_n = 1'b0; res_ready = 1'b0;
    req0_valid = 1'b0; req0_a = '0; req0_b = '0; req0_cin = 1'b0;
    req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_cin = 1'b0;
`ifdef FA_SEQ_SUB_EN
    req0_sub = 1'b0; req1_sub = 1'b0;
`endif

    // Reset state, with both requesters already asserting valid.
    @(negedge clk);
    req0_valid = 1'b1; req0_a = 8'h01; req0_b = 8'h01;
    req1_valid = 1'b1; req1_a = 8'h01; req1_b = 8'h01;
    #1;
    chk("rst_ready", {30'b0, req0_ready, req1_ready}, 32'd0);
    chk("rst_fa", {29'b0, fa_a, fa_b, fa_cin}, 32'd0);
    chk("rst_res", {21'b0, res_valid, res_sum, res_cout, res_id}, 32'd0);

    // Contention straight out of reset: req0 first, req1 next.
    @(negedge clk);
    rst_n = 1'b1;
    issue(1'b0, 8'h01, 8'h01, 1'b0, 1'b0);
    #1;
    chk("run_req1_blocked", {31'b0, req1_ready}, 32'd0);
    get_result(0, 1'b1);
    issue(1'b1, 8'h01, 8'h01, 1'b0, 1'b0);
    get_result(0, 1'b1);

    // Basic add with first-bit FA drive check.
    issue(1'b0, 8'h5A, 8'h33, 1'b0, 1'b0);
    #1;
    chk("run_fa_bit0", {29'b0, fa_a, fa_b, fa_cin}, 32'b010);
    get_result(0, 1'b1);

    // Full carry ripple and wrap-around.
    issue(1'b1, 8'hFF, 8'h01, 1'b0, 1'b0);
    get_result(0, 1'b1);

    // Stall in DONE while req1 waits; req1 only accepted after the handshake.
    issue(1'b0, 8'h80, 8'h80, 1'b1, 1'b0);
    req1_valid = 1'b1; req1_a = 8'h0F; req1_b = 8'h01; req1_cin = 1'b0;
    get_result(5, 1'b1);
    issue(1'b1, 8'h0F, 8'h01, 1'b0, 1'b0);
    get_result(0, 1'b1);

    // Reset during RUN bit 3 abandons the operation and clears the pointer.
    issue(1'b0, 8'hFF, 8'hFF, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    #1;
    chk("pre_abort_fa_a", {31'b0, fa_a}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("abort_fa", {29'b0, fa_a, fa_b, fa_cin}, 32'd0);
    chk("abort_res", {21'b0, res_valid, res_sum, res_cout, res_id}, 32'd0);
    chk("abort_ready", {30'b0, req0_ready, req1_ready}, 32'd0);
    void'(exp_q.pop_back());
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (15) begin
      @(negedge clk);
      #1;
      if (res_valid) seen++;
    end
    chk("no_result_after_abort", seen, 32'd0);
    @(negedge clk);
    req1_valid = 1'b1; req1_a = 8'h11; req1_b = 8'h22; req1_cin = 1'b0;
    issue(1'b0, 8'h12, 8'h34, 1'b1, 1'b0);
    req1_valid = 1'b0;
    get_result(0, 1'b1);

`ifdef FA_SEQ_SUB_EN
    issue(1'b0, 8'h10, 8'h01, 1'b0, 1'b1);
    get_result(0, 1'b1);
    issue(1'b1, 8'h00, 8'h01, 1'b0, 1'b1);
    get_result(0, 1'b1);
`endif

    chk("scoreboard_drained", exp_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
